// File: rtl/demux_1_4_buf.sv
// Registered 1-to-4 demultiplexer: routes one result word into one of four holding slots,
// each slot keeping its word until that slot's consumer acknowledges it.
module demux_1_4_buf #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       m,
   output logic [3:0]       out_valid,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   input  logic [3:0]       out_ack,
   output logic             busy
);

   logic [3:0]       valid_q;
   logic [3:0]       valid_d;
   logic [WIDTH-1:0] data_q [4];
   logic             acc;

   // An ack in the same cycle frees the selected slot, so back-to-back words see no bubble.
   assign in_ready = ~valid_q[m] | out_ack[m];
   assign acc      = in_valid & in_ready;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      valid_d = valid_q & ~out_ack;
      if (acc) begin
         valid_d[m] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         valid_q <= valid_d;
      end
   end

   // NOTE: the holding registers are reset as well, since consumers may observe them right after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
         end
      end else if (acc) begin
         data_q[m] <= in_data;
      end
   end

   assign out_valid = valid_q;
   assign out_data0 = data_q[0];
   assign out_data1 = data_q[1];
   assign out_data2 = data_q[2];
   assign out_data3 = data_q[3];
   assign busy      = |valid_q;

endmodule
